// File: rtl/divisor_detector_pkg.sv
// Shared constants, code/state encodings and the period decoder.
package divisor_detector_pkg;

    localparam int unsigned CNT_W              = 6;
    localparam int unsigned SEL_W              = 3;
    localparam int unsigned MATCH_W            = 6;
    localparam int unsigned TIMEOUT_DEFAULT    = 32;
    localparam int unsigned LOCK_COUNT_DEFAULT = 2;

    typedef enum logic [SEL_W-1:0] {
        CODE_STATIC = 3'd0,
        CODE_DIV2   = 3'd1,
        CODE_DIV4   = 3'd2,
        CODE_DIV8   = 3'd3,
        CODE_DIV16  = 3'd4
    } code_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    typedef struct packed {
        logic  ok;
        code_e code;
    } decode_t;

    // Map a measured edge-to-edge period onto a division code.
    function automatic decode_t decode_period(input logic [CNT_W-1:0] period);
        decode_t d;
        d.ok   = 1'b1;
        d.code = CODE_STATIC;
        case (period)
            6'd2:    d.code = CODE_DIV2;
            6'd4:    d.code = CODE_DIV4;
            6'd8:    d.code = CODE_DIV8;
            6'd16:   d.code = CODE_DIV16;
            default: d.ok   = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/divisor_detector_if.sv
// Signal/result bundle between the waveform source and the detector.
interface divisor_detector_if;
    import divisor_detector_pkg::*;

    logic             iSignal;
    logic [SEL_W-1:0] ovSel;
    logic             oValid;
    logic             oError;

    modport master (output iSignal, input ovSel, oValid, oError);
    modport slave  (input iSignal, output ovSel, oValid, oError);
endinterface

// File: rtl/divisor_detector_edge_detector.sv
// Two-stage input register with rising-edge event.
module edge_detector (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise_c
);

    logic r_sig;
    logic r_prev;

    // Sample the input and keep one cycle of history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig  <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_sig  <= sig;
            r_prev <= r_sig;
        end
    end

    assign rise_c = r_sig & ~r_prev;

endmodule

// File: rtl/divisor_detector.sv
// Measures the period of a divided clock and locks onto its division code.
module divisor_detector
    import divisor_detector_pkg::*;
#(
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT,
    parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
    input  logic              iClk,
    input  logic              iReset,
    divisor_detector_if.slave bus
);

    logic               rise_c;
    logic [CNT_W-1:0]   cnt;
    logic               timeout_c;
    decode_t            dec_c;
    logic [MATCH_W-1:0] match_new_c;
    logic               lock_c;

    state_e             state, state_nxt;
    code_e              sel, sel_nxt;
    code_e              cand, cand_nxt;
    logic [MATCH_W-1:0] match, match_nxt;
    logic               valid, valid_nxt;
    logic               error, error_nxt;

    edge_detector u_edge (
        .clk    (iClk),
        .rst    (iReset),
        .sig    (bus.iSignal),
        .rise_c (rise_c)
    );

    // Period counter: restarts at each edge so that in an edge cycle it
    // already holds the number of cycles since the previous edge.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            cnt <= '0;
        end else if (rise_c) begin
            cnt <= CNT_W'(1);
        end else if (cnt < CNT_W'(TIMEOUT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign timeout_c   = (cnt == CNT_W'(TIMEOUT)) && !rise_c;
    assign dec_c       = decode_period(cnt);
    assign match_new_c = (dec_c.code == cand) ? match + MATCH_W'(1) : MATCH_W'(1);
    assign lock_c      = match_new_c >= MATCH_W'(LOCK_COUNT);

    // State register.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an edge wins over a coincident timeout.
    always_comb begin
        state_nxt = state;
        if (rise_c) begin
            case (state)
                IDLE:    state_nxt = MEASURE;
                MEASURE: if (dec_c.ok && lock_c) state_nxt = LOCKED;
                LOCKED:  if (!dec_c.ok || dec_c.code != sel) state_nxt = MEASURE;
                default: state_nxt = IDLE;
            endcase
        end else if (timeout_c) begin
            state_nxt = LOCKED;
        end
    end

    // Output and candidate tracking logic.
    always_comb begin
        sel_nxt   = sel;
        valid_nxt = valid;
        error_nxt = 1'b0;
        cand_nxt  = cand;
        match_nxt = match;
        if (rise_c && state != IDLE) begin
            if (!dec_c.ok) begin
                error_nxt = 1'b1;
                valid_nxt = 1'b0;
                match_nxt = '0;
            end else if (state == MEASURE) begin
                cand_nxt  = dec_c.code;
                match_nxt = match_new_c;
                if (lock_c) begin
                    sel_nxt   = dec_c.code;
                    valid_nxt = 1'b1;
                end
            end else if (dec_c.code != sel) begin
                valid_nxt = 1'b0;
                cand_nxt  = dec_c.code;
                match_nxt = MATCH_W'(1);
            end
        end else if (!rise_c && timeout_c) begin
            sel_nxt   = CODE_STATIC;
            valid_nxt = 1'b1;
        end
    end

    // Registered outputs and measurement history.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            sel   <= CODE_STATIC;
            valid <= 1'b0;
            error <= 1'b0;
            cand  <= CODE_STATIC;
            match <= '0;
        end else begin
            sel   <= sel_nxt;
            valid <= valid_nxt;
            error <= error_nxt;
            cand  <= cand_nxt;
            match <= match_nxt;
        end
    end

    assign bus.ovSel  = sel;
    assign bus.oValid = valid;
    assign bus.oError = error;

endmodule

// File: tb/tb_divisor_detector.sv
// Directed checks of period decode, locking, errors, timeout and reset.
module tb_divisor_detector;

    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_err_pulse = 0;
    int   e0;

    divisor_detector_if bus ();

    divisor_detector dut (
        .iClk   (clk),
        .iReset (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Count error-pulse cycles.
    always @(posedge clk) begin
        if (bus.oError === 1'b1) n_err_pulse <= n_err_pulse + 1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic sig_val);
        rst         = 1'b1;
        bus.iSignal = sig_val;
        step(2);
        rst = 1'b0;
    endtask

    // One rising edge followed by a full period of the given length.
    task automatic edge_pulse(input int p);
        bus.iSignal = 1'b1;
        step(p / 2);
        bus.iSignal = 1'b0;
        step(p - p / 2);
    endtask

    task automatic check_out(input string tag, input logic [31:0] sel, input logic [31:0] valid);
        check_val({tag, "_sel"}, 32'(bus.ovSel), sel);
        check_val({tag, "_valid"}, 32'(bus.oValid), valid);
    endtask

    initial begin
        // Reset values
        rst         = 1'b1;
        bus.iSignal = 1'b0;
        step(2);
        check_out("reset", 0, 0);
        check_val("reset_error", 32'(bus.oError), 0);

        // Period 2 locks after the third edge
        rst = 1'b0;
        e0  = n_err_pulse;
        for (int i = 0; i < 20; i++) begin
            bus.iSignal = (i % 2 == 0);
            step(1);
            if (i == 4) check_val("p2_before_lock", 32'(bus.oValid), 0);
            if (i == 5) check_out("p2_lock", 1, 1);
        end
        check_out("p2_hold", 1, 1);
        check_val("p2_no_error", 32'(n_err_pulse - e0), 0);

        // Static input: lock to code 0 the cycle after the counter hits 32
        do_reset(1'b0);
        step(32);
        check_val("static_pre", 32'(bus.oValid), 0);
        step(1);
        check_out("static_lock", 0, 1);
        step(7);
        check_out("static_hold", 0, 1);

        // High at reset release: edge in first cycle delays timeout by one
        do_reset(1'b1);
        step(33);
        check_val("high_rel_pre", 32'(bus.oValid), 0);
        step(1);
        check_out("high_rel_lock", 0, 1);

        // Period 16 then period 4
        do_reset(1'b0);
        repeat (3) edge_pulse(16);
        check_out("p16_lock", 4, 1);
        edge_pulse(4);
        check_out("p16_last", 4, 1);
        edge_pulse(4);
        check_out("p4_first", 4, 0);
        edge_pulse(4);
        check_out("p4_lock", 2, 1);

        // One-cycle reset while locked at /16, then relock
        do_reset(1'b0);
        repeat (3) edge_pulse(16);
        check_out("rst_pre", 4, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_out("rst_mid", 0, 0);
        check_val("rst_mid_error", 32'(bus.oError), 0);
        repeat (2) edge_pulse(16);
        check_val("relock_pre", 32'(bus.oValid), 0);
        edge_pulse(16);
        check_out("relock", 4, 1);

        // Period 6 inside a locked period-8 stream
        do_reset(1'b0);
        repeat (3) edge_pulse(8);
        check_out("p8_lock", 3, 1);
        e0 = n_err_pulse;
        edge_pulse(6);
        check_out("p8_before_bad", 3, 1);
        edge_pulse(8);
        check_val("p6_valid", 32'(bus.oValid), 0);
        check_val("p6_err_count", 32'(n_err_pulse - e0), 1);
        edge_pulse(8);
        check_val("p8_good1", 32'(bus.oValid), 0);
        edge_pulse(8);
        check_out("p8_relock", 3, 1);
        check_val("p8_err_total", 32'(n_err_pulse - e0), 1);

        // Edges exactly 32 apart: each measured period is an error
        do_reset(1'b0);
        e0 = n_err_pulse;
        repeat (4) edge_pulse(32);
        check_val("p32_err_count", 32'(n_err_pulse - e0), 3);
        check_val("p32_valid", 32'(bus.oValid), 0);
        step(1);
        check_val("p32_no_static", 32'(bus.oValid), 0);
        step(1);
        check_out("p32_then_static", 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
